// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the flag unit.
//   flags_t           : packed {c,z} pair, the unit of a shadow-stack entry
//   SHADOW_DEPTH_DEF  : default number of nested interrupt save entries
package flag_pkg;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  localparam int SHADOW_DEPTH_DEF = 4;

endpackage

// File: rtl/flag_shadow_stack.sv
// flag_shadow_stack: LIFO of saved {c,z} flag pairs for nested interrupts.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push, pop   : requests; a push while full or a pop while empty is dropped
//   din         : entry to push
//   dout        : current top entry (valid while !empty)
//   full, empty : registered occupancy == DEPTH / == 0
// Entries are held as a shift register with the top at stk[0], so a push
// shifts toward deeper slots and a pop shifts toward the top.
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = SHADOW_DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t dout,
  output logic   full,
  output logic   empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]                cnt, cnt_nxt;
  flags_t [DEPTH-1:0]           stk;
  // ext[0] = incoming entry, ext[g+1] = stk[g], ext[DEPTH+1] = fill for a pop
  flags_t [DEPTH+1:0]           ext;
  logic                         wr, rd;

  assign wr   = push & ~full;
  assign rd   = pop & ~empty;
  assign ext  = {flags_t'(2'b00), stk, din};
  assign dout = stk[0];

  always_comb begin
    cnt_nxt = cnt;
    if (wr)      cnt_nxt = cnt + 1'b1;
    else if (rd) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      stk   <= '0;
    end else begin
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
      for (int g = 0; g < DEPTH; g++) begin
        if (wr)      stk[g] <= ext[g];
        else if (rd) stk[g] <= ext[g+2];
      end
    end
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: carry / zero / interrupt-enable flag register with a nested
// interrupt shadow stack for {C,Z}.
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   C_IN, Z_IN                : ALU carry / zero results
//   FLG_LD_C, FLG_LD_Z        : load C / Z from the ALU
//   FLG_C_SET, FLG_C_CLR      : SEC / CLC
//   ZCHAIN                    : multi-byte ADDC/SUBC (FLAG_ZCHAIN_EN only)
//   FLG_SHAD_SAVE/RESTORE     : interrupt entry (push, clear I) / return (pop)
//   I_SET, I_CLR              : SEI / CLI
//   C_FLAG, Z_FLAG, I_FLAG    : registered flags
//   SHAD_FULL, SHAD_EMPTY     : stack occupancy status
//   SHAD_ERR                  : sticky overflow / underflow / save+restore clash
// Build option: define FLAG_ZCHAIN_EN to make a chained Z load accumulate
// (Z <= Z & Z_IN) so a multi-byte result is zero only if every byte was.
module flag_unit
  import flag_pkg::*;
#(
  parameter int SHADOW_DEPTH = SHADOW_DEPTH_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic FLG_LD_C,
  input  logic FLG_LD_Z,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic ZCHAIN,
  input  logic FLG_SHAD_SAVE,
  input  logic FLG_SHAD_RESTORE,
  input  logic I_SET,
  input  logic I_CLR,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic SHAD_FULL,
  output logic SHAD_EMPTY,
  output logic SHAD_ERR
);

  flags_t top;
  logic   clash, pop_ok, err_now;
  logic   c_nxt, z_nxt, z_ld;

  // A simultaneous save and restore is treated as an error and neither
  // request reaches the stack.
  assign clash   = FLG_SHAD_SAVE & FLG_SHAD_RESTORE;
  assign pop_ok  = FLG_SHAD_RESTORE & ~FLG_SHAD_SAVE & ~SHAD_EMPTY;
  assign err_now = clash | (FLG_SHAD_SAVE & SHAD_FULL) | (FLG_SHAD_RESTORE & SHAD_EMPTY);

  flag_shadow_stack #(.DEPTH(SHADOW_DEPTH)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .push  (FLG_SHAD_SAVE & ~FLG_SHAD_RESTORE),
    .pop   (FLG_SHAD_RESTORE & ~FLG_SHAD_SAVE),
    .din   ('{c: C_FLAG, z: Z_FLAG}),
    .dout  (top),
    .full  (SHAD_FULL),
    .empty (SHAD_EMPTY)
  );

`ifdef FLAG_ZCHAIN_EN
  assign z_ld = ZCHAIN ? (Z_FLAG & Z_IN) : Z_IN;
`else
  logic unused_zchain;
  assign unused_zchain = ZCHAIN;
  assign z_ld          = Z_IN;
`endif

  always_comb begin
    c_nxt = C_FLAG;
    if (pop_ok)         c_nxt = top.c;
    else if (FLG_C_CLR) c_nxt = 1'b0;
    else if (FLG_C_SET) c_nxt = 1'b1;
    else if (FLG_LD_C)  c_nxt = C_IN;

    z_nxt = Z_FLAG;
    if (pop_ok)        z_nxt = top.z;
    else if (FLG_LD_Z) z_nxt = z_ld;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      C_FLAG   <= 1'b0;
      Z_FLAG   <= 1'b0;
      I_FLAG   <= 1'b0;
      SHAD_ERR <= 1'b0;
    end else begin
      C_FLAG   <= c_nxt;
      Z_FLAG   <= z_nxt;
      SHAD_ERR <= SHAD_ERR | err_now;
      if (FLG_SHAD_SAVE | I_CLR) I_FLAG <= 1'b0;
      else if (I_SET)            I_FLAG <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed checks of flag_unit. Each step compares the packed
// observation {C,Z,I,FULL,EMPTY,ERR} against a hand-computed vector.
module tb_flag_unit;

  logic CLK = 1'b0;
  logic RST, C_IN, Z_IN, FLG_LD_C, FLG_LD_Z, FLG_C_SET, FLG_C_CLR, ZCHAIN;
  logic FLG_SHAD_SAVE, FLG_SHAD_RESTORE, I_SET, I_CLR;
  logic C_FLAG, Z_FLAG, I_FLAG, SHAD_FULL, SHAD_EMPTY, SHAD_ERR;
  logic [5:0] obs;
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  assign obs = {C_FLAG, Z_FLAG, I_FLAG, SHAD_FULL, SHAD_EMPTY, SHAD_ERR};

  flag_unit #(.SHADOW_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN),
    .FLG_LD_C(FLG_LD_C), .FLG_LD_Z(FLG_LD_Z),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .ZCHAIN(ZCHAIN),
    .FLG_SHAD_SAVE(FLG_SHAD_SAVE), .FLG_SHAD_RESTORE(FLG_SHAD_RESTORE),
    .I_SET(I_SET), .I_CLR(I_CLR),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
    .SHAD_FULL(SHAD_FULL), .SHAD_EMPTY(SHAD_EMPTY), .SHAD_ERR(SHAD_ERR)
  );

  task automatic idle();
    RST = 0; C_IN = 0; Z_IN = 0; FLG_LD_C = 0; FLG_LD_Z = 0;
    FLG_C_SET = 0; FLG_C_CLR = 0; ZCHAIN = 0;
    FLG_SHAD_SAVE = 0; FLG_SHAD_RESTORE = 0; I_SET = 0; I_CLR = 0;
  endtask

  // one clock with the currently driven controls, then sample and idle
  task automatic tick();
    @(posedge CLK); #1;
    idle();
  endtask

  task automatic do_reset();
    RST = 1; tick();
  endtask

  task automatic test_reset();
    RST = 1; FLG_C_SET = 1; FLG_LD_Z = 1; Z_IN = 1; I_SET = 1; FLG_SHAD_SAVE = 1; tick();
    total++; if (obs !== 6'b000010) begin bad++; $display("FAIL reset got=%b exp=%b", obs, 6'b000010); end
  endtask

  task automatic test_load();
    FLG_LD_C = 1; C_IN = 1; FLG_LD_Z = 1; Z_IN = 1; tick();
    total++; if (obs !== 6'b110010) begin bad++; $display("FAIL load_cz got=%b exp=%b", obs, 6'b110010); end
    FLG_C_CLR = 1; FLG_C_SET = 1; tick();
    total++; if (obs !== 6'b010010) begin bad++; $display("FAIL clr_over_set got=%b exp=%b", obs, 6'b010010); end
    FLG_C_CLR = 1; FLG_LD_C = 1; C_IN = 1; tick();
    total++; if (obs !== 6'b010010) begin bad++; $display("FAIL clr_over_ld got=%b exp=%b", obs, 6'b010010); end
    FLG_C_SET = 1; FLG_LD_C = 1; C_IN = 0; tick();
    total++; if (obs !== 6'b110010) begin bad++; $display("FAIL set_over_ld got=%b exp=%b", obs, 6'b110010); end
    FLG_LD_C = 1; C_IN = 0; FLG_LD_Z = 1; Z_IN = 0; tick();
    total++; if (obs !== 6'b000010) begin bad++; $display("FAIL load_zero got=%b exp=%b", obs, 6'b000010); end
    I_SET = 1; tick();
    total++; if (obs !== 6'b001010) begin bad++; $display("FAIL sei got=%b exp=%b", obs, 6'b001010); end
    I_SET = 1; I_CLR = 1; tick();
    total++; if (obs !== 6'b000010) begin bad++; $display("FAIL cli_over_sei got=%b exp=%b", obs, 6'b000010); end
  endtask

  task automatic test_save_restore();
    do_reset();
    FLG_LD_C = 1; C_IN = 1; FLG_LD_Z = 1; Z_IN = 0; I_SET = 1; tick();
    total++; if (obs !== 6'b101010) begin bad++; $display("FAIL sr_setup got=%b exp=%b", obs, 6'b101010); end
    FLG_SHAD_SAVE = 1; I_SET = 1; tick();
    total++; if (obs !== 6'b100000) begin bad++; $display("FAIL sr_save got=%b exp=%b", obs, 6'b100000); end
    FLG_LD_C = 1; C_IN = 0; FLG_LD_Z = 1; Z_IN = 1; tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL sr_modify got=%b exp=%b", obs, 6'b010000); end
    FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b100010) begin bad++; $display("FAIL sr_restore got=%b exp=%b", obs, 6'b100010); end
    // save pushes the old flags while same-cycle loads update the live ones
    FLG_SHAD_SAVE = 1; FLG_LD_C = 1; C_IN = 0; FLG_LD_Z = 1; Z_IN = 1; tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL save_with_load got=%b exp=%b", obs, 6'b010000); end
    FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b100010) begin bad++; $display("FAIL restore_old got=%b exp=%b", obs, 6'b100010); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_v [9] = '{6'b100010, 6'b010000, 6'b110000, 6'b000000, 6'b000100,
                              6'b100101, 6'b000001, 6'b110001, 6'b010001};
    do_reset();
    FLG_LD_C = 1; C_IN = 1; tick();                                    // p0 = {1,0}
    total++; if (obs !== exp_v[0]) begin bad++; $display("FAIL ovf_p0 got=%b exp=%b", obs, exp_v[0]); end
    FLG_SHAD_SAVE = 1; FLG_LD_C = 1; C_IN = 0; FLG_LD_Z = 1; Z_IN = 1; tick();   // p1 = {0,1}
    total++; if (obs !== exp_v[1]) begin bad++; $display("FAIL ovf_save1 got=%b exp=%b", obs, exp_v[1]); end
    FLG_SHAD_SAVE = 1; FLG_LD_C = 1; C_IN = 1; tick();                 // p2 = {1,1}
    total++; if (obs !== exp_v[2]) begin bad++; $display("FAIL ovf_save2 got=%b exp=%b", obs, exp_v[2]); end
    FLG_SHAD_SAVE = 1; FLG_LD_C = 1; C_IN = 0; FLG_LD_Z = 1; Z_IN = 0; tick();   // p3 = {0,0}
    total++; if (obs !== exp_v[3]) begin bad++; $display("FAIL ovf_save3 got=%b exp=%b", obs, exp_v[3]); end
    FLG_SHAD_SAVE = 1; tick();
    total++; if (obs !== exp_v[4]) begin bad++; $display("FAIL ovf_full got=%b exp=%b", obs, exp_v[4]); end
    FLG_SHAD_SAVE = 1; FLG_LD_C = 1; C_IN = 1; tick();
    total++; if (obs !== exp_v[5]) begin bad++; $display("FAIL ovf_err got=%b exp=%b", obs, exp_v[5]); end
    for (int k = 6; k < 9; k++) begin
      FLG_SHAD_RESTORE = 1; tick();
      total++; if (obs !== exp_v[k]) begin bad++; $display("FAIL ovf_pop%0d got=%b exp=%b", k - 5, obs, exp_v[k]); end
    end
    FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b100011) begin bad++; $display("FAIL ovf_pop4 got=%b exp=%b", obs, 6'b100011); end
  endtask

  task automatic test_empty_err();
    do_reset();
    FLG_LD_C = 1; C_IN = 1; FLG_LD_Z = 1; Z_IN = 1; tick();
    total++; if (obs !== 6'b110010) begin bad++; $display("FAIL ee_setup got=%b exp=%b", obs, 6'b110010); end
    FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b110011) begin bad++; $display("FAIL underflow got=%b exp=%b", obs, 6'b110011); end
    FLG_SHAD_RESTORE = 1; FLG_LD_C = 1; C_IN = 0; tick();
    total++; if (obs !== 6'b010011) begin bad++; $display("FAIL underflow_ld got=%b exp=%b", obs, 6'b010011); end
    do_reset();
    total++; if (obs !== 6'b000010) begin bad++; $display("FAIL err_cleared got=%b exp=%b", obs, 6'b000010); end
    FLG_LD_C = 1; C_IN = 1; tick();
    FLG_SHAD_SAVE = 1; tick();
    I_SET = 1; tick();
    total++; if (obs !== 6'b101000) begin bad++; $display("FAIL clash_setup got=%b exp=%b", obs, 6'b101000); end
    FLG_SHAD_SAVE = 1; FLG_SHAD_RESTORE = 1; FLG_LD_Z = 1; Z_IN = 1; tick();
    total++; if (obs !== 6'b110001) begin bad++; $display("FAIL clash got=%b exp=%b", obs, 6'b110001); end
    FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b100011) begin bad++; $display("FAIL clash_pop got=%b exp=%b", obs, 6'b100011); end
  endtask

  task automatic test_zchain();
    logic [5:0] exp_chain;
`ifdef FLAG_ZCHAIN_EN
    exp_chain = 6'b000010;
`else
    exp_chain = 6'b010010;
`endif
    do_reset();
    FLG_LD_Z = 1; Z_IN = 0; tick();
    FLG_LD_Z = 1; ZCHAIN = 1; Z_IN = 1; tick();
    total++; if (obs !== exp_chain) begin bad++; $display("FAIL zchain_hold got=%b exp=%b", obs, exp_chain); end
    FLG_LD_Z = 1; Z_IN = 1; tick();
    FLG_LD_Z = 1; ZCHAIN = 1; Z_IN = 1; tick();
    total++; if (obs !== 6'b010010) begin bad++; $display("FAIL zchain_one got=%b exp=%b", obs, 6'b010010); end
    FLG_LD_Z = 1; ZCHAIN = 1; Z_IN = 0; tick();
    total++; if (obs !== 6'b000010) begin bad++; $display("FAIL zchain_zero got=%b exp=%b", obs, 6'b000010); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    FLG_LD_C = 1; C_IN = 1; FLG_LD_Z = 1; Z_IN = 1; I_SET = 1; tick();
    FLG_SHAD_SAVE = 1; tick();
    FLG_SHAD_SAVE = 1; tick();
    FLG_SHAD_SAVE = 1; FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b110001) begin bad++; $display("FAIL rm_setup got=%b exp=%b", obs, 6'b110001); end
    RST = 1; FLG_SHAD_SAVE = 1; FLG_LD_C = 1; C_IN = 1; I_SET = 1; tick();
    total++; if (obs !== 6'b000010) begin bad++; $display("FAIL rm_reset got=%b exp=%b", obs, 6'b000010); end
    FLG_SHAD_RESTORE = 1; tick();
    total++; if (obs !== 6'b000011) begin bad++; $display("FAIL rm_stack_empty got=%b exp=%b", obs, 6'b000011); end
  endtask

  initial begin
    idle();
    RST = 1;
    @(negedge CLK);
    test_reset();
    test_load();
    test_save_restore();
    test_overflow();
    test_empty_err();
    test_zchain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have parameter SHADOW_DEPTH, default 4, giving the number of nested interrupt flag-save entries (legal 1..8).
REQ-002 SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port C_IN  input  1  carry result from the ALU.
REQ-005 SHALL have port Z_IN  input  1  zero result from the ALU.
REQ-006 SHALL have port FLG_LD_C  input  1  load C_FLAG from C_IN.
REQ-007 SHALL have port FLG_LD_Z  input  1  load Z_FLAG from Z_IN.
REQ-008 SHALL have port FLG_C_SET  input  1  force C_FLAG to 1 (SEC).
REQ-009 SHALL have port FLG_C_CLR  input  1  force C_FLAG to 0 (CLC).
REQ-010 SHALL have port ZCHAIN  input  1  current op is a multi-byte ADDC/SUBC; used only when FLAG_ZCHAIN_EN is defined.
REQ-011 SHALL have port FLG_SHAD_SAVE  input  1  interrupt entry: push {C,Z}, clear I.
REQ-012 SHALL have port FLG_SHAD_RESTORE  input  1  return from interrupt: pop {C,Z}.
REQ-013 SHALL have port I_SET  input  1  enable interrupts (SEI).
REQ-014 SHALL have port I_CLR  input  1  disable interrupts (CLI).
REQ-015 SHALL have port C_FLAG  output  1  registered carry flag.
REQ-016 SHALL have port Z_FLAG  output  1  registered zero flag.
REQ-017 SHALL have port I_FLAG  output  1  registered interrupt-enable flag.
REQ-018 SHALL have port SHAD_FULL / SHAD_EMPTY  output  1 each  stack occupancy == SHADOW_DEPTH / == 0.
REQ-019 SHALL have port SHAD_ERR  output  1  sticky overflow/underflow indication.

Function
REQ-020 All outputs SHALL be registered; a control asserted in cycle N SHALL be visible at the outputs in cycle N+1.
REQ-021 C next-value priority SHALL be: pop (restore) > FLG_C_CLR > FLG_C_SET > FLG_LD_C > hold.
REQ-022 Z next-value priority SHALL be: pop (restore) > FLG_LD_Z > hold.
REQ-023 A save SHALL push the currently registered {C_FLAG,Z_FLAG}; same-cycle loads/set/clr SHALL still update the live flags.
REQ-024 A save SHALL clear I_FLAG, overriding I_SET; otherwise I_CLR > I_SET > hold.
REQ-025 A restore on a non-empty stack SHALL pop the top entry into C_FLAG/Z_FLAG and leave I_FLAG unchanged.
REQ-026 A save while SHAD_FULL SHALL not push, SHALL set SHAD_ERR, and SHALL still clear I_FLAG.
REQ-027 A restore while SHAD_EMPTY SHALL leave the flags and stack unchanged and SHALL set SHAD_ERR; the live flags SHALL then follow REQ-021/022 without a pop.
REQ-028 Simultaneous save and restore SHALL change neither the stack nor the popped flags, SHALL set SHAD_ERR, and SHALL still clear I_FLAG.
REQ-029 The stack SHALL be LIFO; the occupancy counter SHALL never wrap past 0 or SHADOW_DEPTH.
REQ-030 SHAD_ERR SHALL clear only on reset.

Reset
REQ-031 With RST high at a rising edge: C_FLAG=0, Z_FLAG=0, I_FLAG=0, occupancy=0 (SHAD_EMPTY=1, SHAD_FULL=0), SHAD_ERR=0.
REQ-032 Reset SHALL override every control input in the same cycle, including a save or restore in progress.

Configuration
REQ-033 Macro FLAG_ZCHAIN_EN: when defined, FLG_LD_Z with ZCHAIN=1 SHALL load Z_FLAG <= Z_FLAG & Z_IN; when undefined, ZCHAIN SHALL be ignored and Z_FLAG <= Z_IN.

Structure
REQ-034 Package flag_pkg SHALL hold the flags_t packed struct {c,z} and the default SHADOW_DEPTH constant.
REQ-035 The LIFO SHALL be the sub-module flag_shadow_stack (push, pop, data in/out, full, empty); all other logic stays in flag_unit.

Verification
REQ-036 Reset, then FLG_LD_C=1,C_IN=1 and FLG_LD_Z=1,Z_IN=1 -> next cycle C_FLAG=1, Z_FLAG=1; FLG_C_CLR and FLG_C_SET together -> C_FLAG=0.
REQ-037 Flags {C=1,Z=0}, save; then FLG_LD_C with C_IN=0 and FLG_LD_Z with Z_IN=1; then restore -> after restore C_FLAG=1, Z_FLAG=0, I_FLAG=0.
REQ-038 Five saves with SHADOW_DEPTH=4 -> SHAD_FULL=1 after the fourth, SHAD_ERR=1 after the fifth; four restores pop in reverse order, ending with SHAD_EMPTY=1.
REQ-039 Restore on an empty stack -> flags unchanged, SHAD_ERR=1; save+restore in the same cycle -> occupancy unchanged, I_FLAG=0, SHAD_ERR=1.
REQ-040 FLAG_ZCHAIN_EN defined: Z_FLAG=0, then FLG_LD_Z,ZCHAIN=1,Z_IN=1 -> Z_FLAG stays 0; undefined -> Z_FLAG=1.
REQ-041 RST asserted during a save with occupancy=2 -> next cycle all outputs at their reset values.
